// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding the single register file write port.
// Optional macro REGFILE_WB_BYPASS_EN adds same-edge read bypass outputs.
module regfile_wb_arbiter #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_REQ   = 2,
    localparam int AW = $clog2(NUM_REGS),
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           reqValid,
    input  logic [NUM_REQ*AW-1:0]        reqAddr,
    input  logic [NUM_REQ*REG_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]           reqReady,
    output logic                         wrEn,
    output logic [AW-1:0]                wrAddr,
    output logic [REG_WIDTH-1:0]         wrData,
    output logic [IW-1:0]                grantIdx
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [AW-1:0]                rs1Addr,
    input  logic [AW-1:0]                rs2Addr,
    output logic                         rs1Fwd,
    output logic                         rs2Fwd,
    output logic [REG_WIDTH-1:0]         fwdData
`endif
);

    // Handshake: a requester transfers on the posedge where reqValid[i] & reqReady[i];
    // it holds addr/data stable until then, and reqReady never depends on anything but
    // reqValid, rst and the round-robin pointer.

    localparam logic [IW:0]   NREQ_X   = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    logic [IW-1:0]        r_rr_ptr;
    logic                 w_any;
    logic [IW-1:0]        w_gidx;
    logic [IW:0]          w_scan;
    logic [AW-1:0]        w_addr;
    logic [REG_WIDTH-1:0] w_data;

    // Scan from the pointer with an explicit wrap so non-power-of-2 counts work.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_scan = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_scan >= NREQ_X) begin
                w_scan = w_scan - NREQ_X;
            end
            if (!w_any && reqValid[w_scan[IW-1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_scan[IW-1:0];
            end
        end
        if (rst) begin
            w_any = 1'b0;
        end
    end

    always_comb begin
        reqReady = '0;
        if (w_any) begin
            reqReady[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gidx == IW'(i)) begin
                w_addr = reqAddr[i*AW +: AW];
                w_data = reqData[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Writes to x0 are consumed like any other grant but never raise wrEn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            wrEn     <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            grantIdx <= '0;
        end else begin
            wrEn <= w_any && (w_addr != '0);
            if (w_any) begin
                wrAddr   <= w_addr;
                wrData   <= w_data;
                grantIdx <= w_gidx;
                r_rr_ptr <= (w_gidx == LAST_IDX) ? '0 : w_gidx + 1'b1;
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign rs1Fwd  = wrEn && (wrAddr == rs1Addr) && (rs1Addr != '0);
    assign rs2Fwd  = wrEn && (wrAddr == rs2Addr) && (rs2Addr != '0);
    assign fwdData = wrData;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter: a 2-requester and a 3-requester instance.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 2-requester instance
  logic        rst = 1'b1;
  logic [1:0]  reqValid = '0;
  logic [9:0]  reqAddr = '0;
  logic [63:0] reqData = '0;
  logic [1:0]  reqReady;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [0:0]  grantIdx;

  // 3-requester instance
  logic        rst3 = 1'b1;
  logic [2:0]  valid3 = '0;
  logic [14:0] addr3 = {5'd3, 5'd2, 5'd1};
  logic [95:0] data3 = {32'h30, 32'h20, 32'h10};
  logic [2:0]  ready3;
  logic        wen3;
  logic [4:0]  waddr3;
  logic [31:0] wdata3;
  logic [1:0]  gidx3;

`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  rs1Addr = 5'd7;
  logic [4:0]  rs2Addr = 5'd0;
  logic        rs1Fwd, rs2Fwd;
  logic [31:0] fwdData;
  logic        rs1Fwd3, rs2Fwd3;
  logic [31:0] fwdData3;
`endif

  regfile_wb_arbiter #(.REG_WIDTH(32), .NUM_REGS(32), .NUM_REQ(2)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqAddr(reqAddr), .reqData(reqData),
    .reqReady(reqReady), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .grantIdx(grantIdx)
`ifdef REGFILE_WB_BYPASS_EN
    , .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Fwd(rs1Fwd), .rs2Fwd(rs2Fwd), .fwdData(fwdData)
`endif
  );

  regfile_wb_arbiter #(.REG_WIDTH(32), .NUM_REGS(32), .NUM_REQ(3)) dut3 (
    .clk(clk), .rst(rst3), .reqValid(valid3), .reqAddr(addr3), .reqData(data3),
    .reqReady(ready3), .wrEn(wen3), .wrAddr(waddr3), .wrData(wdata3), .grantIdx(gidx3)
`ifdef REGFILE_WB_BYPASS_EN
    , .rs1Addr(5'd0), .rs2Addr(5'd0), .rs1Fwd(rs1Fwd3), .rs2Fwd(rs2Fwd3), .fwdData(fwdData3)
`endif
  );

  // Expected output register: {wrEn, wrAddr, wrData, grantIdx(2b)}
  logic [39:0] exp_q[$];
  logic [39:0] exp3_q[$];
  logic [39:0] mon_e;
  logic [39:0] mon3_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step2(input logic r, input logic [1:0] v,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [1:0] er, input logic ew, input logic [4:0] ea,
                       input logic [31:0] ed, input logic [1:0] eg);
    @(negedge clk);
    rst      = r;
    reqValid = v;
    reqAddr  = {a1, a0};
    reqData  = {d1, d0};
    #1;
    check("reqReady", 64'(reqReady), 64'(er));
    exp_q.push_back({ew, ea, ed, eg});
  endtask

  task automatic step3(input logic r, input logic [2:0] v, input logic [2:0] er,
                       input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                       input logic [1:0] eg);
    @(negedge clk);
    rst3   = r;
    valid3 = v;
    #1;
    check("reqReady3", 64'(ready3), 64'(er));
    exp3_q.push_back({ew, ea, ed, eg});
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("wrEn", 64'(wrEn), 64'(mon_e[39]));
      check("wrAddr", 64'(wrAddr), 64'(mon_e[38:34]));
      check("wrData", 64'(wrData), 64'(mon_e[33:2]));
      check("grantIdx", 64'(grantIdx), 64'(mon_e[1:0]));
`ifdef REGFILE_WB_BYPASS_EN
      check("rs1Fwd", 64'(rs1Fwd), 64'(mon_e[39] && (mon_e[38:34] == 5'd7)));
      check("rs2Fwd", 64'(rs2Fwd), 64'(0));
      check("fwdData", 64'(fwdData), 64'(mon_e[33:2]));
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp3_q.size() > 0) begin
      mon3_e = exp3_q.pop_front();
      check("wrEn3", 64'(wen3), 64'(mon3_e[39]));
      check("wrAddr3", 64'(waddr3), 64'(mon3_e[38:34]));
      check("wrData3", 64'(wdata3), 64'(mon3_e[33:2]));
      check("grantIdx3", 64'(gidx3), 64'(mon3_e[1:0]));
    end
  end

  initial begin
    // Reset held 3 cycles with both requesting: no grants, outputs cleared
    for (int i = 0; i < 3; i++)
      step2(1, 2'b11, 5'd3, 32'hA0, 5'd4, 32'hB1, 2'b00, 0, 5'd0, 32'h0, 2'd0);
    // Single request, then idle: one cycle of wrEn, fields hold
    step2(0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b01, 1, 5'd5, 32'hDEADBEEF, 2'd0);
    step2(0, 2'b00, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b00, 0, 5'd5, 32'hDEADBEEF, 2'd0);
    // Contention from reset: alternate 0,1,0,1
    step2(1, 2'b11, 5'd3, 32'hA0, 5'd4, 32'hB1, 2'b00, 0, 5'd0, 32'h0, 2'd0);
    step2(0, 2'b11, 5'd3, 32'hA0, 5'd4, 32'hB1, 2'b01, 1, 5'd3, 32'hA0, 2'd0);
    step2(0, 2'b11, 5'd3, 32'hA0, 5'd4, 32'hB1, 2'b10, 1, 5'd4, 32'hB1, 2'd1);
    step2(0, 2'b11, 5'd3, 32'hA0, 5'd4, 32'hB1, 2'b01, 1, 5'd3, 32'hA0, 2'd0);
    step2(0, 2'b11, 5'd3, 32'hA0, 5'd4, 32'hB1, 2'b10, 1, 5'd4, 32'hB1, 2'd1);
    // x0 write from requester 1: consumed, wrEn stays low, pointer wraps to 0
    step2(0, 2'b10, 5'd0, 32'h0, 5'd0, 32'h1234, 2'b10, 0, 5'd0, 32'h1234, 2'd1);
    step2(0, 2'b11, 5'd9, 32'h11, 5'd10, 32'h22, 2'b01, 1, 5'd9, 32'h11, 2'd0);
    // Same destination from both: winner first, loser writes next cycle
    step2(0, 2'b11, 5'd12, 32'hAAAA, 5'd12, 32'hBBBB, 2'b10, 1, 5'd12, 32'hBBBB, 2'd1);
    step2(0, 2'b01, 5'd12, 32'hAAAA, 5'd12, 32'hBBBB, 2'b01, 1, 5'd12, 32'hAAAA, 2'd0);
    step2(0, 2'b00, 5'd12, 32'hAAAA, 5'd12, 32'hBBBB, 2'b00, 0, 5'd12, 32'hAAAA, 2'd0);
    // Requester 0 again with pointer at 1: still granted
    step2(0, 2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 2'b01, 1, 5'd6, 32'h66, 2'd0);
    step2(0, 2'b00, 5'd6, 32'h66, 5'd0, 32'h0, 2'b00, 0, 5'd6, 32'h66, 2'd0);
    // Mid-stream reset: pointer at 1, in-flight wrEn cleared, restart from 0
    step2(0, 2'b01, 5'd7, 32'h77, 5'd8, 32'h88, 2'b01, 1, 5'd7, 32'h77, 2'd0);
    step2(1, 2'b11, 5'd7, 32'h77, 5'd8, 32'h88, 2'b00, 0, 5'd0, 32'h0, 2'd0);
    step2(0, 2'b11, 5'd7, 32'h77, 5'd8, 32'h88, 2'b01, 1, 5'd7, 32'h77, 2'd0);
    step2(0, 2'b10, 5'd7, 32'h77, 5'd8, 32'h88, 2'b10, 1, 5'd8, 32'h88, 2'd1);
    step2(0, 2'b00, 5'd7, 32'h77, 5'd8, 32'h88, 2'b00, 0, 5'd8, 32'h88, 2'd1);

    // Three requesters: move pointer to 2, then all valid -> 2,0,1,2
    step3(1, 3'b000, 3'b000, 0, 5'd0, 32'h0, 2'd0);
    step3(0, 3'b010, 3'b010, 1, 5'd2, 32'h20, 2'd1);
    step3(0, 3'b111, 3'b100, 1, 5'd3, 32'h30, 2'd2);
    step3(0, 3'b111, 3'b001, 1, 5'd1, 32'h10, 2'd0);
    step3(0, 3'b111, 3'b010, 1, 5'd2, 32'h20, 2'd1);
    step3(0, 3'b111, 3'b100, 1, 5'd3, 32'h30, 2'd2);

    for (int i = 0; i < 5 && (exp_q.size() + exp3_q.size()) > 0; i++)
      @(negedge clk);
    check("drain", 64'(exp_q.size() + exp3_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
